// File: rtl/multitap_line_buffer.sv
// Multi-channel line buffer that presents NUM_TAPS vertically spaced samples per channel, with runtime spacing reconfiguration.
// Optional feature: define MULTITAP_BORDER_REPLICATE_EN to replicate the top border into unfilled taps.
module multitap_line_buffer #(
  parameter int DATA_BITS       = 8,
  parameter int CHANNELS        = 3,
  parameter int NUM_TAPS        = 3,
  parameter int MAX_TAP_SPACING = 1024,
  parameter int COORD_BITS      = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_cfg_load,
  input  logic [COORD_BITS-1:0]        in_tap_spacing,
  input  logic                         in_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] in_data,
  output logic                         out_valid,
  output logic [NUM_TAPS*CHANNELS*DATA_BITS-1:0] out_data,
  output logic [NUM_TAPS-1:0]          out_tap_filled,
  output logic                         out_cfg_error
);
  localparam int W         = CHANNELS*DATA_BITS;
  localparam int RAM_W     = (NUM_TAPS-1)*W;
  localparam int ADDR_BITS = (MAX_TAP_SPACING > 1) ? $clog2(MAX_TAP_SPACING) : 1;
  localparam int SP_BITS   = $clog2(MAX_TAP_SPACING+1);
  localparam int FILL_BITS = $clog2((NUM_TAPS-1)*MAX_TAP_SPACING+1);

  logic [RAM_W-1:0] mem [MAX_TAP_SPACING];

  logic [SP_BITS-1:0]   s_q, s_d;
  logic [ADDR_BITS-1:0] a_q, a_d;
  logic [FILL_BITS-1:0] f_q, f_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
  logic [RAM_W-1:0]     pend_word_q, pend_word_d;
  logic                 out_valid_q, out_valid_d;
  logic [NUM_TAPS-1:0][W-1:0] out_data_q, out_data_d;
  logic [NUM_TAPS-1:0]  out_filled_q, out_filled_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 cfg_bad;
  logic [RAM_W-1:0]     rd_word;
  logic [FILL_BITS-1:0] f_max;
  logic [NUM_TAPS-1:0][W-1:0] taps_raw, taps_msk;
  logic [NUM_TAPS-1:0]  filled;
  logic [W-1:0]         border;

  always_comb begin
    cfg_bad = (in_tap_spacing == '0) ||
              ({1'b0, in_tap_spacing} > (COORD_BITS+1)'(MAX_TAP_SPACING));
    // The previous sample's write is still pending; forward it on an address match.
    rd_word = (pend_vld_q && pend_addr_q == a_q) ? pend_word_q : mem[a_q];
    f_max   = FILL_BITS'(NUM_TAPS-1) * FILL_BITS'(s_q);

    taps_raw[0] = in_data;
    for (int i = 1; i < NUM_TAPS; i++) taps_raw[i] = rd_word[(i-1)*W +: W];

    border = in_data;
    for (int i = 0; i < NUM_TAPS; i++) begin
      filled[i] = f_q >= (FILL_BITS'(i) * FILL_BITS'(s_q));
      if (filled[i]) begin
        taps_msk[i] = taps_raw[i];
        border      = taps_raw[i];
      end else begin
`ifdef MULTITAP_BORDER_REPLICATE_EN
        taps_msk[i] = border;
`else
        taps_msk[i] = '0;
`endif
      end
    end

    s_d          = s_q;
    a_d          = a_q;
    f_d          = f_q;
    pend_vld_d   = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_word_d  = pend_word_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_filled_d = out_filled_q;
    cfg_err_d    = 1'b0;

    if (in_cfg_load) begin
      cfg_err_d = cfg_bad;
      if (!cfg_bad) begin
        s_d = SP_BITS'(in_tap_spacing);
        a_d = '0;
        f_d = '0;
      end
    end else if (in_valid) begin
      out_valid_d  = 1'b1;
      out_data_d   = taps_msk;
      out_filled_d = filled;
      pend_vld_d   = 1'b1;
      pend_addr_d  = a_q;
      pend_word_d  = RAM_W'(rd_word << W) | RAM_W'(in_data);
      a_d = (SP_BITS'(a_q) == s_q - SP_BITS'(1)) ? '0 : a_q + ADDR_BITS'(1);
      f_d = (f_q == f_max) ? f_max : f_q + FILL_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q          <= SP_BITS'(MAX_TAP_SPACING);
      a_q          <= '0;
      f_q          <= '0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_word_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_filled_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      s_q          <= s_d;
      a_q          <= a_d;
      f_q          <= f_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      pend_word_q  <= pend_word_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_filled_q <= out_filled_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Reset clears pend_vld_q asynchronously, which suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (pend_vld_q) mem[pend_addr_q] <= pend_word_q;
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_tap_filled = out_filled_q;
  assign out_cfg_error  = cfg_err_q;
endmodule

// File: doc/multitap_line_buffer.md
# multitap_line_buffer

Multi-channel, runtime-reconfigurable successor to the team's RAM tap shift register. It delays a pixel stream by whole multiples of a programmable tap spacing, normally the line width, to present a vertical window of NUM_TAPS samples per channel. It sits between the pixel source and the window/convolution stages. Over the earlier block it adds reconfiguration without reset, config validation, a registered output valid, per-tap fill tracking with masking of unfilled taps, and read/write hazard forwarding.

## Interface
- DATA_BITS, 8: bits per channel sample.
- CHANNELS, 3: channels carried side by side per sample.
- NUM_TAPS, 3: window height; tap 0 is the current sample.
- MAX_TAP_SPACING, 1024: largest legal spacing; RAM depth; ADDR_BITS = max(1, $clog2(MAX_TAP_SPACING)).
- COORD_BITS, 11: width of the spacing input.
- W (derived) = CHANNELS*DATA_BITS; RAM width = (NUM_TAPS-1)*W.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_cfg_load  in  1  load in_tap_spacing this cycle.
- in_tap_spacing  in  COORD_BITS  new spacing S, legal range 1..MAX_TAP_SPACING.
- in_valid  in  1  sample accepted this cycle; no backpressure.
- in_data  in  W  sample; channel c occupies bits [c*DATA_BITS +: DATA_BITS].
- out_valid  out  1  out_data and out_tap_filled are valid.
- out_data  out  NUM_TAPS*W  tap i occupies bits [i*W +: W]; a higher tap index holds older data.
- out_tap_filled  out  NUM_TAPS  bit i set when tap i holds real data.
- out_cfg_error  out  1  one-cycle pulse flagging a rejected config.

## Operation
- State: spacing S, address A (0..S-1), fill count F (saturates at (NUM_TAPS-1)*S), one-deep pending-write register.
- Reset: S=MAX_TAP_SPACING, A=0, F=0, pending cleared, all outputs 0. RAM contents are not cleared.
- Accepted sample at address A (read-modify-write):
  - Cycle t: read RAM[A].
  - Cycle t+1: tap 0 = in_data; tap i = stored slot i-1.
  - Write RAM[A] = {slots 0..NUM_TAPS-3 of the read word, in_data}.
  - Then A = (A==S-1) ? 0 : A+1.
  - F = min(F+1, (NUM_TAPS-1)*S).
- Tap i therefore equals the sample accepted exactly i*S accepted samples earlier.
- Hazard: if a read address equals the pending write address (always true when S=1; also back-to-back same address), the read data is taken from the pending write, not from RAM.
- Fill: out_tap_filled[i] = (F_before_sample >= i*S). Bit 0 is always 1 on valid output.
- Masking: an unfilled tap drives 0 (see Configuration).
- Config, when in_cfg_load=1:
  - Legal spacing: S=in_tap_spacing, A=0, F=0, pending cleared.
  - Illegal spacing (0 or >MAX_TAP_SPACING): state unchanged; out_cfg_error=1 on the next cycle.
  - in_cfg_load takes precedence over a simultaneous in_valid; that sample is dropped and produces no out_valid.
- A config load arriving while a sample is in flight does not cancel it; that sample still completes its write and its output.
- Samples need not be contiguous; idle cycles do not advance A or F.

## Timing
- Latency: out_valid is asserted exactly 1 cycle after an accepted in_valid, with out_data/out_tap_filled registered on the same edge.
- Throughput: one sample per cycle sustained for any S, including S=1.
- out_valid, out_cfg_error: single-cycle pulses.
- out_data and out_tap_filled hold their value while out_valid=0.
- Reset asserted mid-stream: outputs go to 0 asynchronously. An in-flight sample is discarded and its RAM write is suppressed.
- Wrap-around: A goes from S-1 to 0 with no bubble.
- F saturation: F holds at (NUM_TAPS-1)*S with no overflow.

## Configuration
- MULTITAP_BORDER_REPLICATE_EN
  - Defined: an unfilled tap i drives the data of the highest-index filled tap below it, which replicates the top border. out_tap_filled is still reported truthfully.
  - Undefined: unfilled taps drive all zeros.

## Test plan
- Reset, load S=4, NUM_TAPS=3, feed the values 1..12 contiguously. Required: out_valid 1 cycle after each input. For input 9, taps = {9,5,1}. out_tap_filled is 001 for inputs 1–4, 011 for inputs 5–8, 111 from input 9 on.
- S=1, feed 10,11,12 back-to-back. Required: for input 12, taps = {12,11,10}, which proves forwarding.
- Load S=0, then S=MAX_TAP_SPACING+1. Required: out_cfg_error pulses once per load, and the stream that follows still uses the previous S.
- Load S=3 with in_valid=1 in the same cycle. Required: no out_valid; the next sample sees out_tap_filled=001.
- Assert reset during a 5-sample stream with S=2. Required: outputs go to 0 immediately; after reconfiguration, no stale data is flagged as filled.
- With MULTITAP_BORDER_REPLICATE_EN defined, S=4, input 2. Required: taps = {2,2,2}. Without the macro: taps = {2,0,0}.
